sgpio_rx: RTL

Serial GPIO receiver in the status CPLD, directly downstream of the baseboard CPLD's SGPIO transmitter. It samples the three SGPIO pins on SYSCLK, deserialises one frame of drive-activity bits per SGPIO_LD-marked frame, and presents the last complete frame as a parallel ACT_LED vector. It also reports per-frame done/error pulses and a link-health flag, and clears the LEDs when the link goes silent.

---
 rtl/sgpio_rx_pkg.sv | 19 +
 rtl/sgpio_sync.sv | 54 +++++
 rtl/sgpio_rx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sgpio_rx_pkg.sv
// sgpio_rx_pkg -- shared status-CPLD constants and SGPIO receiver state encoding.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

package sgpio_rx_pkg;

  localparam int FRAME_BITS_DEF  = 36;
  localparam int TIMEOUT_CYC_DEF = 25000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sgpio_sync.sv
// sgpio_sync -- 2-flop synchroniser with an aligned output stage and optional rising-edge pulse on the MSB.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module sgpio_sync #(
  parameter int WIDTH = 3,
  parameter bit EDGE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rise
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] q_r;

  // The third stage keeps every bit aligned with the registered edge pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
      q_r  <= '0;
    end else begin
      meta <= d;
      sync <= meta;
      q_r  <= sync;
    end
  end

  assign q = q_r;

  generate
    if (EDGE) begin : g_edge
      logic rise_r;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rise_r <= 1'b0;
        end else begin
          rise_r <= sync[WIDTH-1] & ~q_r[WIDTH-1];
        end
      end
      assign rise = rise_r;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/sgpio_rx.sv
// sgpio_rx -- SGPIO frame receiver: deserialises LD-marked frames into ACT_LED with done/error pulses and link timeout.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module sgpio_rx
  import sgpio_rx_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  SYSCLK,
  input  logic                  RESET_N,
  input  logic                  SGPIO_CK,
  input  logic                  SGPIO_LD,
  input  logic                  SGPIO_DATA,
  output logic [FRAME_BITS-1:0] ACT_LED,
  output logic                  FRAME_DONE,
  output logic                  FRAME_ERR,
  output logic                  LINK_OK
);

  localparam int              CW       = $clog2(FRAME_BITS + 1);
  localparam int              TW       = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0]   LAST_IDX = CW'(FRAME_BITS - 1);
  localparam logic [TW-1:0]   TO_MAX   = TW'(TIMEOUT_CYC - 1);

  logic ck_lvl, ld, data, ck_edge, ck_rise;

  sgpio_sync #(.WIDTH(3), .EDGE(1'b1)) u_sync (
    .clk   (SYSCLK),
    .rst_n (RESET_N),
    .d     ({SGPIO_CK, SGPIO_LD, SGPIO_DATA}),
    .q     ({ck_lvl, ld, data}),
    .rise  (ck_edge)
  );

  assign ck_rise = ck_edge & ck_lvl;

  state_t                state, state_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n, led_n;
  logic [CW-1:0]         bit_cnt, bit_cnt_n;
  logic [TW-1:0]         tcnt, tcnt_n;
  logic                  ovr, ovr_n, done_n, err_n, link_n;

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      tcnt       <= '0;
      ovr        <= 1'b0;
      ACT_LED    <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      LINK_OK    <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      tcnt       <= tcnt_n;
      ovr        <= ovr_n;
      ACT_LED    <= led_n;
      FRAME_DONE <= done_n;
      FRAME_ERR  <= err_n;
      LINK_OK    <= link_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    ovr_n     = ovr;
    led_n     = ACT_LED;
    link_n    = LINK_OK;
    done_n    = 1'b0;
    err_n     = 1'b0;
    tcnt_n    = (tcnt == TO_MAX) ? tcnt : tcnt + TW'(1);

    if (ck_rise) begin
      tcnt_n = '0;
      if (ld) begin
        // A new marker always restarts capture; an unfinished frame is a short frame.
        if (state == ST_SHIFT) begin
          err_n = 1'b1;
        end
        shreg_n    = '0;
        shreg_n[0] = data;
        bit_cnt_n  = CW'(1);
        ovr_n      = 1'b0;
        state_n    = ST_SHIFT;
        if (FRAME_BITS == 1) begin
          led_n   = shreg_n;
          done_n  = 1'b1;
          link_n  = 1'b1;
          state_n = ST_DONE;
        end
      end else begin
        case (state)
          ST_SHIFT: begin
            shreg_n[bit_cnt] = data;
            bit_cnt_n        = bit_cnt + CW'(1);
            if (bit_cnt == LAST_IDX) begin
              led_n   = shreg_n;
              done_n  = 1'b1;
              link_n  = 1'b1;
              state_n = ST_DONE;
            end
          end
          ST_DONE: begin
            if (!ovr) begin
              err_n = 1'b1;
              ovr_n = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end else if (tcnt == TO_MAX) begin
      led_n     = '0;
      link_n    = 1'b0;
      state_n   = ST_IDLE;
      bit_cnt_n = '0;
      ovr_n     = 1'b0;
    end
  end

endmodule

`default_nettype wire
